intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 25 ++
 rtl/intr_ctrl_prio_enc.sv | 29 ++
 rtl/intr_ctrl.sv | 131 +++++++++++++
 tb/tb_intr_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intr_ctrl_pkg
// Shared definitions for the interrupt controller core: FSM state encoding,
// the default vector table base, the default line count, the NMI line index
// and the vector address helper.
// -----------------------------------------------------------------------------
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_e;

    localparam logic [15:0] VEC_BASE_DEF = 16'hFFE0;
    localparam int          NMI_IDX      = 15;

    // Each vector table entry is one 16-bit word, so the address steps by 2.
    // The sum wraps modulo 2^16.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input logic [3:0]  num);
        return base + {11'd0, num, 1'b0};
    endfunction

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Fixed-priority encoder: reports whether any bit of the eligible vector is
// set and the index of the highest set bit.
//   elig  : in  N  eligible lines
//   valid : out 1  at least one line eligible
//   idx   : out 4  index of the highest eligible line (0 when none)
// -----------------------------------------------------------------------------
module prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0] elig,
    output logic         valid,
    output logic [3:0]   idx
);

    // Ascending scan: the last hit, i.e. the highest index, wins.
    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Interrupt controller: detects rising edges on request lines, keeps sticky
// pending flags, selects the highest eligible line and offers it to the
// instruction decoder with its vector address. The top line is a
// non-maskable interrupt that may nest once over a service in progress.
//   clk       : in  1       system clock
//   rst       : in  1       asynchronous active-low reset
//   irq_in    : in  NLINES  raw request lines (synchronous to clk)
//   irq_en    : in  NLINES  per-line enable (top bit ignored)
//   gie       : in  1       global interrupt enable
//   irq_ack   : in  1       decoder accepted the offered interrupt
//   reti_done : in  1       decoder finished RETI
//   irq_req   : out 1       interrupt offered
//   irq_num   : out 4       offered line index
//   irq_vec   : out 16      offered vector address
//   irq_pend  : out NLINES  sticky pending flags
//   irq_busy  : out 1       service in progress
// -----------------------------------------------------------------------------
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEF,
    parameter int          NLINES   = NMI_IDX + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NLINES-1:0] irq_in,
    input  logic [NLINES-1:0] irq_en,
    input  logic              gie,
    input  logic              irq_ack,
    input  logic              reti_done,
    output logic              irq_req,
    output logic [3:0]        irq_num,
    output logic [15:0]       irq_vec,
    output logic [NLINES-1:0] irq_pend,
    output logic              irq_busy
);

    localparam logic [NLINES-1:0] NMI_MASK = {1'b1, {(NLINES-1){1'b0}}};
    localparam logic [3:0]        NMI_NUM  = 4'(NLINES-1);

    state_e            state;
    logic [NLINES-1:0] irq_d;
    logic [NLINES-1:0] rise;
    logic [NLINES-1:0] elig;
    logic [NLINES-1:0] clr_mask;
    logic              win_vld;
    logic [3:0]        win_idx;
    logic              ack_take;

    assign rise = irq_in & ~irq_d;
    // NMI bypasses both the per-line enable and the global enable.
    assign elig = irq_pend & ((irq_en & {NLINES{gie}}) | NMI_MASK);
    assign ack_take = (state == ST_REQ) && irq_ack;

    always_comb begin
        clr_mask = '0;
        if (ack_take) begin
            clr_mask[irq_num] = 1'b1;
        end
    end

    prio_enc #(.N(NLINES)) u_prio (
        .elig  (elig),
        .valid (win_vld),
        .idx   (win_idx)
    );

    // Edge sampling and pending flags; a fresh edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d    <= '0;
            irq_pend <= '0;
        end else begin
            irq_d    <= irq_in;
            irq_pend <= (irq_pend & ~clr_mask) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            irq_req  <= 1'b0;
            irq_num  <= 4'd0;
            irq_vec  <= VEC_BASE;
            irq_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state   <= ST_REQ;
                        irq_req <= 1'b1;
                        irq_num <= win_idx;
                        irq_vec <= vec_addr(VEC_BASE, win_idx);
                    end
                end
                ST_REQ: begin
                    // Offered line/vector are frozen here; only ack or loss of
                    // eligibility of that same line moves the FSM.
                    if (irq_ack) begin
                        state    <= ST_SERV;
                        irq_req  <= 1'b0;
                        irq_busy <= 1'b1;
                    end else if (!elig[irq_num]) begin
                        state   <= ST_IDLE;
                        irq_req <= 1'b0;
                    end
                end
                ST_SERV: begin
                    if (reti_done) begin
                        state    <= ST_IDLE;
                        irq_busy <= 1'b0;
                    end else if (irq_pend[NLINES-1] && (irq_num != NMI_NUM)) begin
                        // One level of nesting: only an NMI may preempt, and
                        // never an NMI service.
                        state   <= ST_REQ;
                        irq_req <= 1'b1;
                        irq_num <= NMI_NUM;
                        irq_vec <= vec_addr(VEC_BASE, NMI_NUM);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
// Directed bench for intr_ctrl with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] irq_in;
    logic [15:0] irq_en;
    logic        gie;
    logic        irq_ack;
    logic        reti_done;
    logic        irq_req;
    logic [3:0]  irq_num;
    logic [15:0] irq_vec;
    logic [15:0] irq_pend;
    logic        irq_busy;

    int n_chk;
    int n_pass;

    intr_ctrl #(.VEC_BASE(16'hFFE0), .NLINES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .irq_en    (irq_en),
        .gie       (gie),
        .irq_ack   (irq_ack),
        .reti_done (reti_done),
        .irq_req   (irq_req),
        .irq_num   (irq_num),
        .irq_vec   (irq_vec),
        .irq_pend  (irq_pend),
        .irq_busy  (irq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the given lines; returns after the edge that sets pending.
    task automatic pulse_in(input logic [15:0] m);
        irq_in = m;
        tick();
        irq_in = 16'h0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic reti();
        reti_done = 1'b1;
        tick();
        reti_done = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},  32'(irq_req),  32'd0);
        chk({tag, "_num"},  32'(irq_num),  32'd0);
        chk({tag, "_vec"},  32'(irq_vec),  32'hFFE0);
        chk({tag, "_pend"}, 32'(irq_pend), 32'h0);
        chk({tag, "_busy"}, 32'(irq_busy), 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b0;
        irq_in    = 16'h0;
        irq_en    = 16'h0;
        gie       = 1'b0;
        irq_ack   = 1'b0;
        reti_done = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst0");
        rst = 1'b1;
        tick();

        // Basic offer / ack / reti on line 4
        gie    = 1'b1;
        irq_en = 16'h0010;
        pulse_in(16'h0010);
        chk("l4_pend",   32'(irq_pend), 32'h0010);
        chk("l4_req_c1", 32'(irq_req),  32'd0);
        tick();
        chk("l4_req",  32'(irq_req), 32'd1);
        chk("l4_num",  32'(irq_num), 32'd4);
        chk("l4_vec",  32'(irq_vec), 32'hFFE8);
        ack();
        chk("l4_pend_clr", 32'(irq_pend), 32'h0);
        chk("l4_busy",     32'(irq_busy), 32'd1);
        chk("l4_req_drop", 32'(irq_req),  32'd0);
        ack();
        chk("ack_in_serv_ign", 32'(irq_busy), 32'd1);
        reti();
        chk("l4_reti_busy", 32'(irq_busy), 32'd0);
        reti();
        chk("reti_idle_ign", 32'(irq_req), 32'd0);

        // Priority: lines 2 and 9 together
        irq_en = 16'hFFFF;
        pulse_in(16'h0204);
        tick();
        chk("p9_num", 32'(irq_num), 32'd9);
        chk("p9_vec", 32'(irq_vec), 32'hFFF2);
        ack();
        reti();
        tick();
        chk("p2_req", 32'(irq_req), 32'd1);
        chk("p2_num", 32'(irq_num), 32'd2);
        chk("p2_vec", 32'(irq_vec), 32'hFFE4);
        ack();
        reti();

        // NMI ignores gie/irq_en; maskable line waits for gie
        gie    = 1'b0;
        irq_en = 16'h0000;
        pulse_in(16'h8000);
        tick();
        chk("nmi_req", 32'(irq_req), 32'd1);
        chk("nmi_num", 32'(irq_num), 32'd15);
        chk("nmi_vec", 32'(irq_vec), 32'hFFFE);
        ack();
        reti();
        irq_en = 16'h0008;
        pulse_in(16'h0008);
        tick();
        tick();
        chk("l3_noreq",  32'(irq_req),  32'd0);
        chk("l3_pend",   32'(irq_pend), 32'h0008);
        gie = 1'b1;
        tick();
        chk("l3_req", 32'(irq_req), 32'd1);
        chk("l3_num", 32'(irq_num), 32'd3);
        ack();
        reti();

        // Nesting: NMI preempts service of line 5, line 6 waits
        irq_en = 16'hFFFF;
        pulse_in(16'h0020);
        tick();
        chk("l5_num", 32'(irq_num), 32'd5);
        ack();
        pulse_in(16'h0040);
        tick();
        chk("l6_wait_req",  32'(irq_req),  32'd0);
        chk("l6_wait_pend", 32'(irq_pend), 32'h0040);
        pulse_in(16'h8000);
        tick();
        chk("nest_req",  32'(irq_req),  32'd1);
        chk("nest_num",  32'(irq_num),  32'd15);
        chk("nest_busy", 32'(irq_busy), 32'd1);
        ack();
        chk("nest_pend", 32'(irq_pend), 32'h0040);
        reti();
        chk("nest_reti_busy", 32'(irq_busy), 32'd0);
        tick();
        chk("l6_req", 32'(irq_req), 32'd1);
        chk("l6_num", 32'(irq_num), 32'd6);
        ack();
        reti();

        // Set wins over ack clear on the same line
        pulse_in(16'h0010);
        tick();
        irq_in  = 16'h0010;
        irq_ack = 1'b1;
        tick();
        irq_in  = 16'h0;
        irq_ack = 1'b0;
        chk("setwin_pend", 32'(irq_pend), 32'h0010);
        chk("setwin_busy", 32'(irq_busy), 32'd1);
        reti();
        tick();
        chk("setwin_reoffer", 32'(irq_num), 32'd4);
        chk("setwin_req",     32'(irq_req), 32'd1);
        ack();
        reti();

        // Losing gie while offered
        pulse_in(16'h0080);
        tick();
        chk("l7_num", 32'(irq_num), 32'd7);
        gie = 1'b0;
        tick();
        chk("l7_drop",     32'(irq_req),  32'd0);
        chk("l7_pend",     32'(irq_pend), 32'h0080);
        tick();
        chk("l7_stay_off", 32'(irq_req),  32'd0);
        gie = 1'b1;
        tick();
        chk("l7_reoffer", 32'(irq_req), 32'd1);
        chk("l7_renum",   32'(irq_num), 32'd7);
        ack();
        reti();

        // Reset during service with lines 1 and 3 pending
        pulse_in(16'h0010);
        tick();
        ack();
        pulse_in(16'h000A);
        chk("prerst_pend", 32'(irq_pend), 32'h000A);
        chk("prerst_busy", 32'(irq_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("postrst_req",  32'(irq_req),  32'd0);
        chk("postrst_pend", 32'(irq_pend), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
